// File: rtl/div_repeated_sub.sv
// div_repeated_sub
//   Sequential unsigned divider that works by repeated subtraction. It is the
//   inverse companion of the repeated-addition multiplier and uses the same
//   start/done handshake.
//
//   The dividend and the divisor arrive one after the other on data_in. The
//   divisor is subtracted from the running remainder, and each subtraction
//   adds one to the quotient.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset; clears all state
//   start        begin an operation; sampled only in IDLE or DONE
//   data_in      dividend in the LOAD_A cycle, divisor in the LOAD_B cycle
//   busy         high from LOAD_A through SUB
//   done         high in DONE; the results are valid
//   div_by_zero  high together with done when the divisor was 0
//   quotient     registered quotient (all ones on divide-by-zero)
//   remainder    registered remainder (dividend on divide-by-zero)
//
// Latency
//   start is sampled on edge k.
//   done is high after edge k+4+Q, where Q = dividend / divisor.
//   With a zero divisor, done is high after edge k+4.
module div_repeated_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CHECK  = 3'd3,
    SUB    = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] quot_q,  quot_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] dvsr_q,  dvsr_d;
  logic             dbz_q,   dbz_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_A;
      end

      LOAD_A: begin
        rem_d   = data_in;
        state_d = LOAD_B;
      end

      LOAD_B: begin
        dvsr_d  = data_in;
        quot_d  = '0;
        dbz_d   = 1'b0;
        state_d = CHECK;
      end

      CHECK: begin
        if (dvsr_q == '0) begin
          quot_d = '1;
          dbz_d  = 1'b1;
        end
        // A zero divisor still passes through SUB for one idle cycle. This
        // gives it the same k+4 latency as a zero quotient.
        state_d = SUB;
      end

      SUB: begin
        if (dbz_q) begin
          state_d = DONE;
        end else if (rem_q >= dvsr_q) begin
          // The >= test guarantees the subtraction cannot underflow.
          // The quotient is bounded by the dividend, so it cannot wrap.
          rem_d  = rem_q - dvsr_q;
          quot_d = quot_q + 1'b1;
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (start) state_d = LOAD_A;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == LOAD_A) || (state_q == LOAD_B) ||
                       (state_q == CHECK)  || (state_q == SUB);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;

endmodule

// File: tb/tb_div_repeated_sub.sv
module tb_div_repeated_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  div_repeated_sub #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model state for the operation in flight. Only the driver writes it.
  logic        trk = 1'b0;
  int          k_cyc = 0;
  int          exp_lat = 0;
  logic [15:0] exp_q = '0, exp_r = '0;
  logic        exp_dbz = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the arithmetic model.
  // d is the number of rising edges since start was sampled.
  always @(negedge clk) begin
    int d;
    d = cyc - k_cyc;
    if (trk && !rst && d > 0) begin
      chk("busy", 32'(busy), 32'(d < exp_lat));
      chk("done", 32'(done), 32'(d >= exp_lat));
      if (d >= exp_lat) begin
        chk("model_q",   32'(quotient),    32'(exp_q));
        chk("model_r",   32'(remainder),   32'(exp_r));
        chk("model_dbz", 32'(div_by_zero), 32'(exp_dbz));
      end
    end
  end

  // Drives start, then the dividend, then the divisor.
  // Returns at the negedge that follows edge k+2.
  task automatic begin_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'($urandom);
    k_cyc   = cyc + 1;
    exp_dbz = (b == 16'd0);
    exp_q   = (b == 16'd0) ? 16'hFFFF : a / b;
    exp_r   = (b == 16'd0) ? a : a % b;
    exp_lat = (b == 16'd0) ? 4 : 4 + int'(a / b);
    trk     = 1'b1;
    @(negedge clk); start = 1'b0; data_in = a;
    @(negedge clk); data_in = b;
    @(negedge clk); data_in = 16'($urandom);
  endtask

  task automatic run(input string nm, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] lq, input logic [15:0] lr, input logic ldbz,
                     input int llat, input int pulse_at);
    int seen;
    seen = -1;
    begin_op(a, b);
    for (int i = 3; i < llat + 20; i++) begin
      @(negedge clk);
      start = (i == pulse_at);
      if (done) begin
        seen = i;
        break;
      end
    end
    start = 1'b0;
    if (seen < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", nm, llat + 20);
    end else begin
      chk({nm, "_lat"}, 32'(seen),        32'(llat));
      chk({nm, "_q"},   32'(quotient),    32'(lq));
      chk({nm, "_r"},   32'(remainder),   32'(lr));
      chk({nm, "_dbz"}, 32'(div_by_zero), 32'(ldbz));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy),        32'd0);
    chk("rst_done", 32'(done),        32'd0);
    chk("rst_dbz",  32'(div_by_zero), 32'd0);
    chk("rst_q",    32'(quotient),    32'd0);
    chk("rst_r",    32'(remainder),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("t1_17_5",    16'd17,    16'd5,     16'd3,     16'd2,   1'b0, 7,     0);
    run("t2_5_17",    16'd5,     16'd17,    16'd0,     16'd5,   1'b0, 4,     0);
    run("t3_div0",    16'd100,   16'd0,     16'hFFFF,  16'd100, 1'b1, 4,     0);
    run("t_zero_div", 16'd0,     16'd7,     16'd0,     16'd0,   1'b0, 4,     0);
    run("t_eq",       16'hFFFF,  16'hFFFF,  16'd1,     16'd0,   1'b0, 5,     0);
    run("t4_max",     16'hFFFF,  16'd1,     16'hFFFF,  16'd0,   1'b0, 65539, 0);
    // start is pulsed mid-SUB and must be ignored. The next run then starts
    // straight out of DONE.
    run("t5_pulse",   16'd1000,  16'd3,     16'd333,   16'd1,   1'b0, 337,   10);
    run("t5_b2b",     16'd20,    16'd4,     16'd5,     16'd0,   1'b0, 9,     0);

    // Reset asserted between edges while the divider is in SUB.
    begin_op(16'd1000, 16'd1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    trk = 1'b0;
    #1;
    chk("t6_busy", 32'(busy),        32'd0);
    chk("t6_done", 32'(done),        32'd0);
    chk("t6_q",    32'(quotient),    32'd0);
    chk("t6_r",    32'(remainder),   32'd0);
    chk("t6_dbz",  32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run("t6_9_3",     16'd9,     16'd3,     16'd3,     16'd0,   1'b0, 7,     0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
